// File: rtl/fifo_drain_uart_tx.sv
// fifo_drain_uart_tx: pops bytes from an external FIFO and serialises them as 8N1 UART frames.
// Latency: rd_en one cycle after IDLE sees data, start bit two cycles after rd_en; frame = 2 + 10*CLKS_PER_BIT.
// Backpressure: pops only when enable=1 and fifo_empty=0, sampled in IDLE; an in-flight frame always completes.
//
// Ports: clk, rst (sync, active-high), enable, fifo_empty, fifo_dout[7:0] -> fifo_rd_en, tx, busy,
//        byte_done, tx_count[15:0].
// Optional: define UART_PARITY_EN to insert an even-parity bit between DATA and STOP.
module fifo_drain_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_dout,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic        byte_done,
  output logic [15:0] tx_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  // byte_done is registered, so it is raised one cycle early to land on the last stop cycle.
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             rd_en_q;
  logic             byte_done_q;
  logic [15:0]      tx_count_q;
`ifdef UART_PARITY_EN
  logic             parity_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      rd_en_q     <= 1'b0;
      byte_done_q <= 1'b0;
      tx_count_q  <= '0;
`ifdef UART_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      rd_en_q     <= 1'b0;
      byte_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (enable && !fifo_empty) begin
            state_q <= S_READ;
            rd_en_q <= 1'b1;  // high for exactly the READ cycle
          end
        end
        S_READ: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          // FIFO data is valid the cycle after the pop strobe.
          shift_q   <= fifo_dout;
`ifdef UART_PARITY_EN
          parity_q  <= ^fifo_dout;
`endif
          bit_idx_q <= '0;
          cnt_q     <= '0;
          tx_q      <= 1'b0;
          state_q   <= S_START;
        end
        S_START: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          tx_q <= 1'b1;
          if (cnt_q == CNT_MAX) begin
            cnt_q      <= '0;
            tx_count_q <= tx_count_q + 16'd1;  // wraps naturally
            state_q    <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_PRE) begin
              byte_done_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign byte_done  = byte_done_q;
  assign tx_count   = tx_count_q;

endmodule

// File: doc/fifo_drain_uart_tx.md
FIFO_DRAIN_UART_TX -- requirements
Module: fifo_drain_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have port enable, input, 1, drain permission; high allows new FIFO pops.
REQ-005 The block SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-006 The block SHALL have port fifo_dout, input, 8, FIFO read data; valid one cycle after the fifo_rd_en cycle.
REQ-007 The block SHALL have port fifo_rd_en, output, 1, registered one-cycle pop strobe.
REQ-008 The block SHALL have port tx, output, 1, registered UART serial line; idle high.
REQ-009 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-010 The block SHALL have port byte_done, output, 1, one-cycle pulse on the last cycle of each stop bit.
REQ-011 The block SHALL have port tx_count, output, 16, count of completed frames.

Function
REQ-012 The state machine SHALL use states IDLE, READ, LOAD, START, DATA, [PARITY], STOP.
REQ-013 In IDLE, if enable=1 and fifo_empty=0, the block SHALL move to READ; otherwise it SHALL stay in IDLE with tx=1.
REQ-014 In READ (exactly one cycle), fifo_rd_en SHALL be 1; it SHALL be 0 in every other state.
REQ-015 In LOAD (one cycle), the block SHALL capture fifo_dout into an 8-bit shift register, then enter START.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL send 8 bits LSB first, each held for CLKS_PER_BIT cycles, using a 3-bit bit index.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 On the last STOP cycle, byte_done SHALL be 1 and tx_count SHALL increment, wrapping 0xFFFF->0x0000.
REQ-020 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload at each bit boundary, and be sized by $clog2(CLKS_PER_BIT).
REQ-021 fifo_empty and enable SHALL be sampled only in IDLE; changes during READ..STOP SHALL not affect the current frame.
REQ-022 Deasserting enable mid-frame SHALL let the frame complete, with no further pop.
REQ-023 Back-to-back frames SHALL have 3 extra high cycles between stop bit end and next start bit (IDLE, READ, LOAD).
REQ-024 Each frame SHALL produce exactly one fifo_rd_en pulse; an empty FIFO SHALL never be popped (no underflow).
REQ-025 Frame length from READ entry SHALL be 2 + 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL set state=IDLE, tx=1, fifo_rd_en=0, busy=0, byte_done=0, tx_count=0, and clear the baud counter, bit index and shift register.
REQ-027 Reset mid-frame SHALL abandon the frame (byte lost) and issue no pop in the reset cycle or the following cycle.

Configuration
REQ-028 With UART_PARITY_EN defined, a PARITY state SHALL follow DATA and send the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-029 Without UART_PARITY_EN, there SHALL be no PARITY state, and DATA SHALL go directly to STOP.

Verification (CLKS_PER_BIT=4)
REQ-030 Single byte: FIFO holds 0xA5, enable=1 -> one rd_en pulse; tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4; byte_done once; tx_count=1.
REQ-031 Empty FIFO: fifo_empty=1, enable=1 for 100 cycles -> fifo_rd_en never 1, tx=1, busy=0.
REQ-032 Burst: FIFO holds 0x01, 0x80, 0xFF -> 3 rd_en pulses; frames decode to the same bytes in order; 3-cycle high gaps; tx_count=3; then IDLE once empty.
REQ-033 Enable drop: enable goes 0 during frame 2 of 3 -> frame 2 completes; no third pop; tx_count=2.
REQ-034 Reset mid-DATA: rst pulsed during bit 3 -> next cycle tx=1, busy=0, tx_count=0, fifo_rd_en=0; restart pops the next byte.
REQ-035 Parity: with UART_PARITY_EN, byte 0x07 -> parity bit 1; frame is 44 cycles; byte 0x03 -> parity bit 0.
